// File: rtl/if_stage.sv
// if_stage - instruction-fetch stage of the 16-bit five-stage pipeline.
//
// Owns the PC, the instruction-memory request/acknowledge handshake and the
// IF/ID pipeline register. Consumes the decode stage's branch and stall
// requests and implements the single architectural branch delay slot.
//
// Optional feature macro: IF_SKID_EN
//   defined   : 1-entry skid buffer plus HOLD state; fetch continues while
//               stalled so the instruction is ready when the stall releases.
//   undefined : no skid; requests are suppressed while stalled and the same
//               PC is re-requested afterwards.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall_i         decode/hazard stall, freezes IF/ID
//   branch_flag_i   taken branch for the instruction currently in IF/ID
//   branch_addr_i   branch target
//   imem_req_o      fetch request (combinational from state and stall_i)
//   imem_addr_o     fetch address (the registered PC)
//   imem_ack_i      fetch complete, imem_rdata_i valid in the same cycle
//   imem_rdata_i    fetched instruction
//   id_pc_o         fetch address + 1 of the instruction in IF/ID
//   id_inst_o       instruction in IF/ID
//   id_valid_o      IF/ID holds a real instruction (0 = bubble)

module if_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [15:0] imem_rdata_i,
   output logic [15:0] id_pc_o,
   output logic [15:0] id_inst_o,
   output logic        id_valid_o
);

`ifdef IF_SKID_EN
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`else
   typedef enum logic [0:0] {IDLE, FETCH} state_t;
`endif

   state_t      state;
   logic [15:0] pc;
   logic [15:0] pc_inc;
   logic [15:0] next_pc;
   logic [15:0] redir_addr;
   logic        redir_pend;
   logic        branch_take;
`ifdef IF_SKID_EN
   logic [15:0] skid_inst;
   logic [15:0] skid_pc;
`endif

   assign pc_inc      = pc + 16'd1;
   assign imem_addr_o = pc;

   // A branch is only honoured for a real, non-stalled instruction that is
   // not itself in the shadow of an unresolved redirect (delay slot).
   assign branch_take = branch_flag_i && id_valid_o && !stall_i && !redir_pend;

   always_comb begin
      next_pc = pc_inc;
      if (redir_pend)
         next_pc = redir_addr;
      else if (branch_take)
         next_pc = branch_addr_i;
   end

`ifdef IF_SKID_EN
   // With the skid present, FETCH always has an empty skid, so a stall only
   // blocks requests once the skid has filled (HOLD).
   assign imem_req_o = (state == FETCH);
`else
   assign imem_req_o = (state == FETCH) && !stall_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         redir_pend <= 1'b0;
         redir_addr <= '0;
         id_inst_o  <= NOP_INST;
         id_pc_o    <= '0;
         id_valid_o <= 1'b0;
`ifdef IF_SKID_EN
         skid_inst  <= NOP_INST;
         skid_pc    <= '0;
`endif
      end else begin
         case (state)
            IDLE: state <= FETCH;

            FETCH: begin
               if (imem_ack_i && !stall_i) begin
                  id_inst_o  <= imem_rdata_i;
                  id_pc_o    <= pc_inc;
                  id_valid_o <= 1'b1;
                  pc         <= next_pc;
                  redir_pend <= 1'b0;
               end
`ifdef IF_SKID_EN
               else if (imem_ack_i) begin
                  // Stalled: park the fetched word, IF/ID stays frozen.
                  skid_inst  <= imem_rdata_i;
                  skid_pc    <= pc_inc;
                  pc         <= next_pc;
                  redir_pend <= 1'b0;
                  state      <= HOLD;
               end
`endif
               else begin
                  // No usable ack (or stalled without a skid): ack is dropped.
                  if (!stall_i) begin
                     id_inst_o  <= NOP_INST;
                     id_valid_o <= 1'b0;
                  end
                  if (branch_take) begin
                     redir_pend <= 1'b1;
                     redir_addr <= branch_addr_i;
                  end
               end
            end

`ifdef IF_SKID_EN
            HOLD: begin
               if (!stall_i) begin
                  id_inst_o  <= skid_inst;
                  id_pc_o    <= skid_pc;
                  id_valid_o <= 1'b1;
                  state      <= FETCH;
                  // The skid already holds the delay slot, redirect at once.
                  if (branch_take)
                     pc <= branch_addr_i;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit five-stage pipeline. It owns the PC and runs a request/acknowledge fetch handshake with the instruction-memory port, which shares the SRAM with the MEM stage and can be delayed. It also owns the IF/ID pipeline register. It consumes the branch request and stall request that the decode stage produces, and implements the single architectural branch delay slot.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, encoding inserted into IF/ID as a bubble.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  decode/hazard stall; ID holds its instruction while high.
- branch_flag_i  in  1  taken branch from decode, combinational from the current IF/ID contents.
- branch_addr_i  in  16  branch target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  16  fetch address; equals the current PC.
- imem_ack_i  in  1  fetch complete; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  16  fetched instruction.
- id_pc_o  out  16  fetch address + 1 of the instruction in IF/ID.
- id_inst_o  out  16  instruction in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- **States:** IDLE, FETCH, HOLD.
  - Reset forces IDLE.
  - IDLE→FETCH unconditionally on the next cycle.
- **imem_req_o** = (state == FETCH) && !(stall_i && skid full). The exact gating depends on IF_SKID_EN; see Configuration.
- **Accept.** In FETCH with imem_ack_i:
  - If !stall_i: id_inst_o ← imem_rdata_i, id_pc_o ← pc+1, id_valid_o ← 1, pc ← next_pc.
  - If stall_i: the instruction and pc+1 go into the skid buffer, pc ← next_pc, state ← HOLD.
- **Bubble.** In FETCH with no ack and !stall_i: id_inst_o ← NOP_INST, id_valid_o ← 0, id_pc_o unchanged.
- **Stall.** While stall_i is high, IF/ID is frozen (all three id_* outputs hold).
- **HOLD.**
  - imem_req_o is 0.
  - When stall_i falls: IF/ID ← skid contents, id_valid_o ← 1, state ← FETCH. The transfer happens on the first clock edge with stall_i low.
- **Branch sampling.** The branch is sampled only when id_valid_o && !stall_i && !redir_pend. Otherwise branch_flag_i is ignored; a branch in a delay slot is unsupported by the ISA.
- **Delay slot.** The sequentially next instruction after a branch always executes.
  - If the delay-slot fetch is acked in the branch cycle, or already sits in the skid buffer, then next_pc = branch_addr_i.
  - Otherwise redir_pend ← 1 and redir_addr ← branch_addr_i. The fetch at the current PC continues. On its ack, pc ← redir_addr and redir_pend ← 0.
- **next_pc:** redir_addr if redir_pend, else branch_addr_i if the branch is taken this cycle, else pc+1.
- **Arithmetic:** all PC math is 16-bit modulo. 16'hFFFF + 1 wraps to 16'h0000.
- **Reset values:**
  - pc = RESET_PC, state = IDLE, imem_req_o = 0, imem_addr_o = RESET_PC.
  - id_inst_o = NOP_INST, id_pc_o = 0, id_valid_o = 0.
  - redir_pend = 0, skid empty.
  - Reset mid-fetch abandons the outstanding request; a late ack is ignored because state is IDLE.

## Timing
- Fetch latency: the ack cycle's edge loads IF/ID. The minimum is one instruction per cycle with ack tied high.
- First request is asserted 2 cycles after rst deasserts (rst edge → IDLE → FETCH).
- imem_addr_o is registered (pc). imem_req_o is combinational from state and stall_i only; it has no path from imem_ack_i.
- Branch redirect takes effect on the edge that completes the delay-slot fetch. The target address appears on imem_addr_o in the following cycle.
- Simultaneous stall_i fall and branch in HOLD: the skid (delay slot) moves to IF/ID and pc ← branch_addr_i on the same edge.

## Configuration
- **IF_SKID_EN defined:** the 1-entry skid buffer and HOLD state are present. Fetch continues during stall_i, so the instruction is ready when the stall releases.
- **IF_SKID_EN undefined:** there is no skid and no HOLD state. imem_req_o = (state == FETCH) && !stall_i. Any ack arriving while stall_i is high is ignored, and the same PC is re-requested after the stall.

## Test plan
- **Reset, then ack tied 1, rdata = 16'h4901 at PC 0:**
  - imem_req_o first high at cycle 2.
  - Cycle 3: id_inst_o = 16'h4901, id_pc_o = 1, id_valid_o = 1.
  - PC increments by 1 every cycle afterwards.
- **Ack withheld 3 cycles at PC 5:**
  - imem_addr_o stays 5 and id_valid_o = 0 with NOP_INST during the wait.
  - On ack, id_pc_o = 6.
- **Branch with ack present:** branch_flag_i = 1, branch_addr_i = 16'h0040, while IF/ID holds the branch at PC 9.
  - The delay slot at PC 10 is delivered.
  - The next imem_addr_o is 16'h0040.
- **Branch with ack delayed 2 cycles:** redir_pend set; the fetch of PC 10 completes, then imem_addr_o = 16'h0040.
  - A second branch_flag_i pulse during redir_pend has no effect.
- **stall_i high 4 cycles while ack is high (IF_SKID_EN):**
  - IF/ID is frozen and the skid captures PC 7; imem_req_o is 0 in HOLD.
  - On release, id_pc_o = 8 on the first edge.
  - Without the macro: no ack is consumed and PC 7 is re-fetched.
- **Wrap and reset:**
  - PC 16'hFFFF acked → next imem_addr_o = 16'h0000.
  - rst asserted mid-wait → next cycle outputs equal the reset values, and a late ack is ignored.
